// File: rtl/regfile_mp.sv
// Multi-port register file: masked byte writes through a one-entry write stage,
// byte-accurate read forwarding, and a per-register busy scoreboard.
module regfile_mp #(
  parameter  int DATA_W   = 64,
  parameter  int NUM_REGS = 32,
  parameter  int NUM_RD   = 2,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [2:0]               wr_ppp,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic                     wr_err
);
  localparam int NB = DATA_W / 8;

  // Lane parity counts from the most significant byte, so lane = NB-1-b.
  function automatic logic [NB-1:0] ppp_mask(input logic [2:0] ppp);
    logic [NB-1:0] m;
    int l;
    m = '0;
    for (int b = 0; b < NB; b++) begin
      l = NB - 1 - b;
      case (ppp)
        3'b000:  m[b] = 1'b1;
        3'b001:  m[b] = (b >= NB / 2);
        3'b010:  m[b] = (b < NB / 2);
        3'b011:  m[b] = ((l % 2) == 0);
        3'b100:  m[b] = ((l % 2) == 1);
        3'b101:  m[b] = (((l / 2) % 2) == 0);
        3'b110:  m[b] = (((l / 2) % 2) == 1);
        default: m[b] = 1'b0;
      endcase
    end
    return m;
  endfunction

  logic              wr_acc, wr_ill;
  logic [NB-1:0]     wr_mask;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              stg_vld_q, stg_vld_d;
  logic [AW-1:0]     stg_addr_q, stg_addr_d;
  logic [DATA_W-1:0] stg_data_q, stg_data_d;
  logic [NB-1:0]     stg_mask_q, stg_mask_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic              wr_err_q, wr_err_d;

  assign wr_mask = ppp_mask(wr_ppp);
  assign wr_acc  = wr_en && (wr_addr != '0) && (wr_ppp != 3'b111);
  assign wr_ill  = wr_en && (wr_addr != '0) && (wr_ppp == 3'b111);

  always_comb begin
    regs_d = regs_q;
    if (stg_vld_q) begin
      for (int b = 0; b < NB; b++)
        if (stg_mask_q[b]) regs_d[stg_addr_q][8*b +: 8] = stg_data_q[8*b +: 8];
    end
    stg_vld_d  = wr_acc;
    stg_addr_d = wr_addr;
    stg_data_d = wr_data;
    stg_mask_d = wr_mask;
    // Clear on commit first so a same-edge reserve wins.
    busy_d = busy_q;
    if (stg_vld_q) busy_d[stg_addr_q] = 1'b0;
    if (rsv_en && (rsv_addr != '0)) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
    wr_err_d = wr_ill;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      stg_vld_q  <= 1'b0;
      stg_addr_q <= '0;
      stg_data_q <= '0;
      stg_mask_q <= '0;
      busy_q     <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      stg_vld_q  <= stg_vld_d;
      stg_addr_q <= stg_addr_d;
      stg_data_q <= stg_data_d;
      stg_mask_q <= stg_mask_d;
      busy_q     <= busy_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign wr_err = wr_err_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] d;
    assign a = rd_addr[k*AW +: AW];
    // Per byte: live write beats the pending stage, which beats the array.
    always_comb begin
      d = regs_q[a];
      for (int b = 0; b < NB; b++) begin
        if (wr_acc && (wr_addr == a) && wr_mask[b])
          d[8*b +: 8] = wr_data[8*b +: 8];
        else if (stg_vld_q && (stg_addr_q == a) && stg_mask_q[b])
          d[8*b +: 8] = stg_data_q[8*b +: 8];
      end
      if (a == '0) d = '0;
    end
    assign rd_data[k*DATA_W +: DATA_W] = d;
    assign rd_busy[k] = busy_q[a];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: expectations are queued as each cycle's stimulus
// is driven, then popped and compared against the outputs of that cycle.
module tb_regfile_mp;
  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;
  logic [1:0]    rd_busy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [2:0]    wr_ppp;
  logic          rsv_en;
  logic [AW-1:0] rsv_addr;
  logic          wr_err;

  regfile_mp dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ppp(wr_ppp),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;  // 0 rd_data, 1 rd_busy, 2 wr_err
    int          port;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic push(input string tag, input int kind, input int port, input logic [63:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.port = port; e.exp = exp;
    q.push_back(e);
  endtask

  // Start a cycle: wait for the falling edge, leave the write/reserve idle.
  task automatic cyc(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    @(negedge clk);
    rd_addr = {a1, a0};
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_ppp = 3'b000;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] p);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_ppp = p;
  endtask

  task automatic drain();
    exp_t e;
    logic [63:0] obs;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        0:       obs = rd_data[e.port*DW +: DW];
        1:       obs = {63'd0, rd_busy[e.port]};
        default: obs = {63'd0, wr_err};
      endcase
      chk(e.tag, obs, e.exp);
    end
  endtask

  localparam logic [63:0] D1 = 64'h1122334455667788;
  localparam logic [63:0] M2 = 64'hAA22AA44AA66AA88;
  localparam logic [63:0] M3 = 64'hAA22FFFFAA66FFFF;
  localparam logic [63:0] R7 = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] X9 = 64'h0123456789ABCDEF;
  localparam logic [63:0] Y9 = 64'hFEDCBA9876543210;

  initial begin
    reset = 1'b1;
    rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_ppp = '0;
    rsv_en = 1'b0; rsv_addr = '0;
    repeat (2) @(posedge clk);

    // reset state
    cyc(5, 9); reset = 1'b0;
    push("rst_rd0", 0, 0, 0); push("rst_busy1", 1, 1, 0); push("rst_err", 2, 0, 0);
    drain();

    // 1: full write, visible live / from stage / from array
    cyc(5, 5); wr(5, D1, 3'b000);
    push("t1_live", 0, 0, D1); drain();
    cyc(5, 0); push("t1_stage", 0, 0, D1); push("t1_r0", 0, 1, 0); drain();
    cyc(5, 0); push("t1_array", 0, 0, D1); drain();

    // 2: even bytes then odd halfwords
    cyc(5, 0); wr(5, {8{8'hAA}}, 3'b011);
    push("t2_even_live", 0, 0, M2); drain();
    cyc(5, 5); wr(5, {8{8'hFF}}, 3'b110);
    push("t2_oddhw_live", 0, 0, M3); push("t2_oddhw_p1", 0, 1, M3); drain();
    cyc(0, 5); push("t2_stage", 0, 1, M3); drain();
    cyc(0, 5); push("t2_array", 0, 1, M3); drain();

    // 3: back-to-back halves to r7 merge
    cyc(0, 7); wr(7, 64'hDEADBEEF00000000, 3'b001);
    push("t3_upper_live", 0, 1, 64'hDEADBEEF00000000); drain();
    cyc(0, 7); wr(7, 64'h00000000CAFEF00D, 3'b010);
    push("t3_merge", 0, 1, R7); drain();
    cyc(7, 7); push("t3_stage", 0, 1, R7); drain();
    cyc(7, 0); push("t3_array", 0, 0, R7); drain();

    // 4: write to r0 dropped, illegal ppp flagged for one cycle
    cyc(0, 0); wr(0, '1, 3'b000);
    push("t4_r0_live", 0, 0, 0); push("t4_err0", 2, 0, 0); drain();
    cyc(3, 0); wr(3, '1, 3'b111);
    push("t4_r0_after", 0, 1, 0); push("t4_err_r0", 2, 0, 0); push("t4_ill_live", 0, 0, 0); drain();
    cyc(3, 0); push("t4_err_pulse", 2, 0, 1); push("t4_r3", 0, 0, 0); drain();
    cyc(3, 0); push("t4_err_gone", 2, 0, 0); push("t4_r3_after", 0, 0, 0); drain();

    // 5: scoreboard
    cyc(0, 9); rsv_en = 1'b1; rsv_addr = 9;
    push("t5_busy_pre", 1, 1, 0); drain();
    cyc(0, 9); wr(9, X9, 3'b000);
    push("t5_busy_set", 1, 1, 1); drain();
    cyc(9, 9); push("t5_busy_stage", 1, 1, 1); drain();
    cyc(9, 9); wr(9, Y9, 3'b000);
    push("t5_busy_clr", 1, 1, 0); push("t5_data", 0, 0, Y9); drain();
    cyc(9, 9); rsv_en = 1'b1; rsv_addr = 9;
    push("t5_busy_commit", 1, 0, 0); drain();
    cyc(9, 9); push("t5_rsv_wins", 1, 1, 1); push("t5_data2", 0, 0, Y9); drain();
    cyc(9, 0); push("t5_busy_hold", 1, 0, 1); push("t5_r0_busy", 1, 1, 0); drain();

    // 6: reset discards a pending write and clears state
    cyc(4, 4); wr(4, D1, 3'b000); rsv_en = 1'b1; rsv_addr = 4;
    push("t6_live", 0, 0, D1); drain();
    cyc(4, 9); reset = 1'b1;
    cyc(4, 9); reset = 1'b0;
    push("t6_r4", 0, 0, 0); push("t6_busy4", 1, 0, 0); push("t6_busy9", 1, 1, 0);
    push("t6_err", 2, 0, 0); push("t6_r5", 0, 1, 0); drain();
    cyc(5, 7); push("t6_r5b", 0, 0, 0); push("t6_r7", 0, 1, 0); drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
